// File: rtl/alarm_pkg.sv
// Shared types and constants for the car alarm controller and its delay store.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_ARMED,
        ST_COUNTDOWN,
        ST_ALARM,
        ST_ALARM_HOLD,
        ST_DISARMED,
        ST_DOOR_OPEN,
        ST_ARMING
    } state_e;

    typedef enum logic [1:0] {
        ARM_DELAY       = 2'd0,
        DRIVER_DELAY    = 2'd1,
        PASSENGER_DELAY = 2'd2,
        ALARM_ON        = 2'd3
    } slot_e;

    localparam logic [3:0] DEFAULT_ARM       = 4'd6;
    localparam logic [3:0] DEFAULT_DRIVER    = 4'd8;
    localparam logic [3:0] DEFAULT_PASSENGER = 4'd15;
    localparam logic [3:0] DEFAULT_ALARM     = 4'd10;

    // Cycles during which a stale expired level from the previous countdown is ignored.
    localparam int BLANK_CYCLES = 2;

endpackage

// File: rtl/time_param_store.sv
// Four programmable 4-bit delay slots with async reset to defaults and a combinational read port.
module time_param_store
    import alarm_pkg::*;
#(
    parameter logic [3:0] ARM_INIT       = DEFAULT_ARM,
    parameter logic [3:0] DRIVER_INIT    = DEFAULT_DRIVER,
    parameter logic [3:0] PASSENGER_INIT = DEFAULT_PASSENGER,
    parameter logic [3:0] ALARM_INIT     = DEFAULT_ALARM
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en_i,
    input  logic [1:0] wr_sel_i,
    input  logic [3:0] wr_data_i,
    input  logic [1:0] rd_sel_i,
    output logic [3:0] rd_data_o
);

    logic [3:0] slot_q [4];

    // NOTE: every slot has a defined power-up value, so this small array is reset like any register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_q[ARM_DELAY]       <= ARM_INIT;
            slot_q[DRIVER_DELAY]    <= DRIVER_INIT;
            slot_q[PASSENGER_DELAY] <= PASSENGER_INIT;
            slot_q[ALARM_ON]        <= ALARM_INIT;
        end else if (wr_en_i) begin
            slot_q[wr_sel_i] <= wr_data_i;
        end
    end

    assign rd_data_o = slot_q[rd_sel_i];

endmodule

// File: rtl/alarm_controller.sv
// Arming/disarming FSM of the car alarm: drives timer start requests, siren and status LED.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter logic [3:0] T_ARM_DEFAULT       = DEFAULT_ARM,
    parameter logic [3:0] T_DRIVER_DEFAULT    = DEFAULT_DRIVER,
    parameter logic [3:0] T_PASSENGER_DEFAULT = DEFAULT_PASSENGER,
    parameter logic [3:0] T_ALARM_DEFAULT     = DEFAULT_ALARM
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       driverDoor,
    input  logic       passengerDoor,
    input  logic       reprogram,
    input  logic [1:0] timeParamSel,
    input  logic [3:0] timeValue,
    input  logic       expired,
    input  logic       clock1Hz,
    output logic       startTimer,
    output logic [3:0] value,
    output logic       siren,
    output logic       statusLed
);

    state_e     state_q, state_d;
    logic       start_q, start_d;
    logic [3:0] value_q, value_d;
    logic       siren_q, siren_d;
    logic       led_q, led_d;
    logic       blank_q, blank_d;
    slot_e      slot_sel;
    logic [3:0] slot_value;
    logic       expired_ok;

    time_param_store #(
        .ARM_INIT       (T_ARM_DEFAULT),
        .DRIVER_INIT    (T_DRIVER_DEFAULT),
        .PASSENGER_INIT (T_PASSENGER_DEFAULT),
        .ALARM_INIT     (T_ALARM_DEFAULT)
    ) u_store (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (reprogram),
        .wr_sel_i  (timeParamSel),
        .wr_data_i (timeValue),
        .rd_sel_i  (slot_sel),
        .rd_data_o (slot_value)
    );

    assign expired_ok = expired && !start_q && (blank_q == 1'b0);

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARMED;
            start_q <= 1'b0;
            value_q <= 4'd0;
            siren_q <= 1'b0;
            led_q   <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            value_q <= value_d;
            siren_q <= siren_d;
            led_q   <= led_d;
            blank_q <= blank_d;
        end
    end

    // NOTE: every output of this block gets a default first, which keeps it free of latches.
    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        slot_sel = ARM_DELAY;
        if (reprogram) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (ignition) begin
                        state_d = ST_DISARMED;
                    end else if (driverDoor) begin
                        start_d  = 1'b1;
                        slot_sel = DRIVER_DELAY;
                        state_d  = ST_COUNTDOWN;
                    end else if (passengerDoor) begin
                        start_d  = 1'b1;
                        slot_sel = PASSENGER_DELAY;
                        state_d  = ST_COUNTDOWN;
                    end
                end
                ST_COUNTDOWN: begin
                    if (ignition)        state_d = ST_DISARMED;
                    else if (expired_ok) state_d = ST_ALARM;
                end
                ST_ALARM: begin
                    if (ignition) begin
                        state_d = ST_DISARMED;
                    end else if (!driverDoor && !passengerDoor) begin
                        start_d  = 1'b1;
                        slot_sel = ALARM_ON;
                        state_d  = ST_ALARM_HOLD;
                    end
                end
                ST_ALARM_HOLD: begin
                    if (ignition)                        state_d = ST_DISARMED;
                    else if (driverDoor || passengerDoor) state_d = ST_ALARM;
                    else if (expired_ok)                 state_d = ST_ARMED;
                end
                ST_DISARMED: begin
                    if (!ignition && driverDoor) state_d = ST_DOOR_OPEN;
                end
                ST_DOOR_OPEN: begin
                    if (ignition) begin
                        state_d = ST_DISARMED;
                    end else if (!driverDoor) begin
                        start_d  = 1'b1;
                        slot_sel = ARM_DELAY;
                        state_d  = ST_ARMING;
                    end
                end
                ST_ARMING: begin
                    if (ignition)        state_d = ST_DISARMED;
                    else if (driverDoor) state_d = ST_DOOR_OPEN;
                    else if (expired_ok) state_d = ST_ARMED;
                end
                default: state_d = ST_ARMED;
            endcase
        end

        value_d = start_d ? slot_value : value_q;

        if (start_q)              blank_d = 1'(BLANK_CYCLES - 1);
        else if (blank_q != 1'b0) blank_d = blank_q - 1'b1;
        else                      blank_d = 1'b0;
    end

    always_comb begin
        siren_d = (state_d == ST_ALARM) || (state_d == ST_ALARM_HOLD);
        case (state_d)
            ST_DISARMED, ST_DOOR_OPEN: led_d = 1'b0;
            ST_ARMED, ST_ARMING:       led_d = clock1Hz;
            default:                   led_d = 1'b1;
        endcase
    end

    assign startTimer = start_q;
    assign value      = value_q;
    assign siren      = siren_q;
    assign statusLed  = led_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed scenarios plus random traffic, checked each cycle against a behavioural alarm model.
module tb_alarm_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ignition = 1'b0;
    logic       driverDoor = 1'b0;
    logic       passengerDoor = 1'b0;
    logic       reprogram = 1'b0;
    logic [1:0] timeParamSel = 2'd0;
    logic [3:0] timeValue = 4'd0;
    logic       clock1Hz = 1'b0;
    logic       startTimer;
    logic [3:0] value;
    logic       siren;
    logic       statusLed;
    logic       expired;

    alarm_controller dut (
        .clock         (clock),
        .reset         (reset),
        .ignition      (ignition),
        .driverDoor    (driverDoor),
        .passengerDoor (passengerDoor),
        .reprogram     (reprogram),
        .timeParamSel  (timeParamSel),
        .timeValue     (timeValue),
        .expired       (expired),
        .clock1Hz      (clock1Hz),
        .startTimer    (startTimer),
        .value         (value),
        .siren         (siren),
        .statusLed     (statusLed)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Timer model: one second = 8 cycles; expired is a level that stays high until the next load.
    int   t_cnt     = 0;
    bit   t_pend    = 0;
    int   t_pend_n  = 0;
    logic timer_exp = 1'b1;
    logic exp_force = 1'b0;
    assign expired = timer_exp | exp_force;

    // Behavioural model of the controller.
    typedef enum {M_ARMED, M_COUNT, M_ALARM, M_HOLD, M_DIS, M_DOOR, M_ARMING} m_state_e;
    m_state_e   m_st;
    logic [3:0] m_slot [4];
    int         m_since;
    logic       m_start, m_siren, m_led;
    logic [3:0] m_value;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] req);
        tests_run++;
        assert (obs === req) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_st      = M_ARMED;
        m_slot[0] = 4'd6;
        m_slot[1] = 4'd8;
        m_slot[2] = 4'd15;
        m_slot[3] = 4'd10;
        m_since   = 99;
        m_start   = 1'b0;
        m_value   = 4'd0;
        m_siren   = 1'b0;
        m_led     = 1'b0;
    endtask

    task automatic model_step();
        m_state_e   n;
        bit         st;
        logic [3:0] sv;
        bit         exp_ok;
        if (reset) begin
            model_reset();
            return;
        end
        exp_ok = expired && (m_since >= 2);
        n  = m_st;
        st = 0;
        sv = 4'd0;
        if (reprogram) begin
            m_slot[timeParamSel] = timeValue;
            n = M_ARMED;
        end else if (m_st != M_DIS && ignition) begin
            n = M_DIS;
        end else begin
            case (m_st)
                M_ARMED:  if (driverDoor)         begin st = 1; sv = m_slot[1]; n = M_COUNT; end
                          else if (passengerDoor) begin st = 1; sv = m_slot[2]; n = M_COUNT; end
                M_COUNT:  if (exp_ok) n = M_ALARM;
                M_ALARM:  if (!driverDoor && !passengerDoor) begin st = 1; sv = m_slot[3]; n = M_HOLD; end
                M_HOLD:   if (driverDoor || passengerDoor) n = M_ALARM;
                          else if (exp_ok) n = M_ARMED;
                M_DIS:    if (!ignition && driverDoor) n = M_DOOR;
                M_DOOR:   if (!driverDoor) begin st = 1; sv = m_slot[0]; n = M_ARMING; end
                M_ARMING: if (driverDoor) n = M_DOOR;
                          else if (exp_ok) n = M_ARMED;
                default:  n = M_ARMED;
            endcase
        end
        m_since = st ? 0 : ((m_since < 99) ? m_since + 1 : 99);
        m_start = st;
        if (st) m_value = sv;
        m_siren = (n == M_ALARM) || (n == M_HOLD);
        if (n == M_DIS || n == M_DOOR)         m_led = 1'b0;
        else if (n == M_ARMED || n == M_ARMING) m_led = clock1Hz;
        else                                    m_led = 1'b1;
        m_st = n;
    endtask

    task automatic timer_step();
        if (t_pend) begin
            t_cnt  = t_pend_n * 8;
            t_pend = 0;
        end else if (t_cnt > 0) begin
            t_cnt--;
        end
        if (startTimer === 1'b1) begin
            t_pend   = 1;
            t_pend_n = int'(value);
        end
        timer_exp = (t_cnt == 0);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_siren"}, {3'd0, siren},      {3'd0, m_siren});
        check({tag, "_start"}, {3'd0, startTimer}, {3'd0, m_start});
        check({tag, "_value"}, value,              m_value);
        check({tag, "_led"},   {3'd0, statusLed},  {3'd0, m_led});
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_outputs("cyc");
        timer_step();
        cyc++;
        clock1Hz = cyc[2];
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs("reset");
        run(2);
        reset = 1'b0;
        run(3);

        // 1: driver door from ARMED starts the 8 s countdown, then the siren.
        driverDoor = 1'b1;
        cycle();
        check("t1_start", {3'd0, startTimer}, 4'd1);
        check("t1_value", value, 4'd8);
        run(70);
        check("t1_siren", {3'd0, siren}, 4'd1);
        check("t1_led", {3'd0, statusLed}, 4'd1);

        // 3: close doors -> hold; reopen mid-hold -> back to ALARM; close and expire -> ARMED.
        driverDoor = 1'b0;
        cycle();
        check("t3_value", value, 4'd10);
        check("t3_start", {3'd0, startTimer}, 4'd1);
        run(20);
        passengerDoor = 1'b1;
        cycle();
        check("t3_reopen_siren", {3'd0, siren}, 4'd1);
        check("t3_reopen_nostart", {3'd0, startTimer}, 4'd0);
        run(5);
        passengerDoor = 1'b0;
        cycle();
        check("t3_restart", {3'd0, startTimer}, 4'd1);
        run(90);
        check("t3_siren_off", {3'd0, siren}, 4'd0);

        // 2: passenger door, then ignition 20 cycles later disarms.
        passengerDoor = 1'b1;
        cycle();
        check("t2_value", value, 4'd15);
        run(20);
        ignition = 1'b1;
        cycle();
        check("t2_siren", {3'd0, siren}, 4'd0);
        check("t2_led", {3'd0, statusLed}, 4'd0);

        // 4: arm sequence with a door reopen that restarts the arm delay.
        passengerDoor = 1'b0;
        ignition = 1'b0;
        driverDoor = 1'b1;
        run(3);
        driverDoor = 1'b0;
        cycle();
        check("t4_value", value, 4'd6);
        run(19);
        driverDoor = 1'b1;
        cycle();
        check("t4_door_led", {3'd0, statusLed}, 4'd0);
        driverDoor = 1'b0;
        cycle();
        check("t4_restart", {3'd0, startTimer}, 4'd1);
        run(60);
        check("t4_armed_siren", {3'd0, siren}, 4'd0);

        // 5: reprogram driver slot to 3, then ignition and expired together in COUNTDOWN.
        reprogram = 1'b1;
        timeParamSel = 2'd1;
        timeValue = 4'd3;
        cycle();
        reprogram = 1'b0;
        driverDoor = 1'b1;
        cycle();
        check("t5_value", value, 4'd3);
        run(5);
        ignition = 1'b1;
        exp_force = 1'b1;
        cycle();
        check("t5_siren", {3'd0, siren}, 4'd0);
        check("t5_led", {3'd0, statusLed}, 4'd0);
        exp_force = 1'b0;

        // 6: reach ALARM_HOLD, then assert reset between edges.
        ignition = 1'b0;
        run(2);
        driverDoor = 1'b0;
        run(60);
        driverDoor = 1'b1;
        run(35);
        driverDoor = 1'b0;
        run(10);
        check("t6_hold_siren", {3'd0, siren}, 4'd1);
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("t6_async");
        run(2);
        reset = 1'b0;
        passengerDoor = 1'b1;
        cycle();
        check("t6_passenger_slot", value, 4'd15);
        run(130);
        passengerDoor = 1'b0;
        cycle();
        check("t6_alarm_slot", value, 4'd10);
        ignition = 1'b1;
        run(2);
        ignition = 1'b0;
        driverDoor = 1'b1;
        run(2);
        driverDoor = 1'b0;
        cycle();
        check("t6_arm_slot", value, 4'd6);
        run(55);
        driverDoor = 1'b1;
        cycle();
        check("t6_driver_slot", value, 4'd8);

        // Random traffic against the model, including zero-length delays.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(39) == 0) ignition = ~ignition;
            if ($urandom_range(15) == 0) driverDoor = ~driverDoor;
            if ($urandom_range(19) == 0) passengerDoor = ~passengerDoor;
            reprogram = ($urandom_range(63) == 0);
            timeParamSel = 2'($urandom_range(3));
            timeValue = 4'($urandom_range(15));
            exp_force = ($urandom_range(31) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
